pdu_dbg: RTL

Parametrised peripheral/debug unit for the single-cycle CPU board top. It sits between the board I/O (switches, buttons, LEDs, 7-segment digits), the CPU's memory-mapped IO bus and its debug bus. It generates the CPU clock in run and step modes, holds the output and ready registers, and scans the digit display over selectable debug views. Compared with the first-generation unit it adds configurable widths and digit count, a CPU-cycle counter, a wider view selector, two-stage input synchronisers and an optional PC breakpoint that halts run mode.

---
 rtl/pdu_dbg.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/pdu_dbg.sv
// Peripheral/debug unit: CPU clock generation, IO registers and a multiplexed hex display.
// Define PDU_BREAKPOINT_EN to build the PC breakpoint (BRK state, bp registers, view 5).
module pdu_dbg #(
    parameter int IN_W      = 5,
    parameter int OUT_W     = 5,
    parameter int DIGITS    = 8,
    parameter int REFRESH_W = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       step,
    output logic                       clk_cpu,
    input  logic                       valid,
    input  logic [IN_W-1:0]            in,
    output logic [2:0]                 check,
    output logic [OUT_W-1:0]           out0,
    output logic                       ready,
    output logic [$clog2(DIGITS)-1:0]  an,
    output logic [3:0]                 seg,
    output logic                       halted,
    input  logic [7:0]                 io_addr,
    input  logic [31:0]                io_dout,
    input  logic                       io_we,
    output logic [31:0]                io_din,
    output logic [7:0]                 m_rf_addr,
    input  logic [31:0]                rf_data,
    input  logic [31:0]                m_data,
    input  logic [31:0]                pc
);
    localparam int          AW   = $clog2(DIGITS);
    localparam int unsigned NDIG = (DIGITS < 8) ? DIGITS : 8;
`ifdef PDU_BREAKPOINT_EN
    localparam logic [2:0] LAST_VIEW = 3'd5;
    typedef enum logic [1:0] {HALT, RUN, STEP, BRK} state_t;
`else
    localparam logic [2:0] LAST_VIEW = 3'd4;
    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;
`endif

    logic            run_m, run_s, step_m, step_s, step_d, valid_m, valid_s, valid_d;
    logic [IN_W-1:0] in_m, in_s;
    logic            step_p, valid_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            {run_m, run_s, step_m, step_s, step_d} <= '0;
            {valid_m, valid_s, valid_d}            <= '0;
            in_m <= '0;
            in_s <= '0;
        end else begin
            run_m   <= run;
            run_s   <= run_m;
            step_m  <= step;
            step_s  <= step_m;
            step_d  <= step_s;
            valid_m <= valid;
            valid_s <= valid_m;
            valid_d <= valid_s;
            in_m    <= in;
            in_s    <= in_m;
        end
    end

    assign step_p    = step_s & ~step_d;
    assign valid_e   = valid_s ^ valid_d;
    assign m_rf_addr = 8'(in_s);

    state_t state, state_nxt;
    logic   clk_nxt;
    logic   rise;

`ifdef PDU_BREAKPOINT_EN
    logic [31:0] bp_r;
    logic        bp_en, run_d, skip, run_fall;
    assign run_fall = run_d & ~run_s;
    assign halted   = (state == BRK);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        clk_nxt   = 1'b0;
        case (state)
            HALT: begin
                if (run_s)       state_nxt = RUN;
                else if (step_p) state_nxt = STEP;
            end
            STEP: begin
                clk_nxt   = 1'b1;
                state_nxt = HALT;
            end
            RUN: begin
                // A high clk_cpu is always brought low first, so HALT/BRK are entered with it at 0.
                if (!clk_cpu) begin
                    if (!run_s) state_nxt = HALT;
`ifdef PDU_BREAKPOINT_EN
                    else if (bp_en && !skip && pc == bp_r) state_nxt = BRK;
`endif
                    else clk_nxt = 1'b1;
                end
            end
`ifdef PDU_BREAKPOINT_EN
            BRK: begin
                if (step_p)        state_nxt = STEP;
                else if (run_fall) state_nxt = HALT;
            end
`endif
            default: state_nxt = HALT;
        endcase
    end

    assign rise = clk_nxt & ~clk_cpu;

    logic [31:0]          cyc_cnt;
    logic [REFRESH_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HALT;
            clk_cpu <= 1'b0;
            cyc_cnt <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            clk_cpu <= clk_nxt;
            cnt     <= cnt + REFRESH_W'(1);
            if (rise) cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    logic [OUT_W-1:0] out0_r;
    logic             ready_r;
    logic [31:0]      out1_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            out0_r  <= '1;
            ready_r <= 1'b1;
            out1_r  <= 32'h1234_5678;
        end else if (io_we) begin
            case (io_addr)
                8'h00:   out0_r  <= io_dout[OUT_W-1:0];
                8'h04:   ready_r <= io_dout[0];
                8'h08:   out1_r  <= io_dout;
                default: ;
            endcase
        end
    end

`ifdef PDU_BREAKPOINT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_r  <= '0;
            bp_en <= 1'b0;
            run_d <= 1'b0;
            skip  <= 1'b0;
        end else begin
            run_d <= run_s;
            // The first rise after leaving HALT bypasses the compare so the CPU can leave the breakpoint PC.
            if (state == HALT && state_nxt == RUN) skip <= 1'b1;
            else if (rise)                         skip <= 1'b0;
            if (io_we && io_addr == 8'h18) begin
                bp_r  <= io_dout;
                bp_en <= 1'b1;
            end else if (io_we && io_addr == 8'h1C) begin
                bp_en <= io_dout[1];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)                   check <= '0;
        else if (run_s || step_p)  check <= '0;
        else if (valid_e)          check <= (check == LAST_VIEW) ? 3'd0 : check + 3'd1;
    end

    always_comb begin
        io_din = '0;
        case (io_addr)
            8'h0C: io_din = 32'(in_s);
            8'h10: io_din = {31'b0, valid_s};
            8'h14: io_din = cyc_cnt;
`ifdef PDU_BREAKPOINT_EN
            8'h18: io_din = bp_r;
            8'h1C: io_din = {30'b0, bp_en, halted};
`endif
            default: ;
        endcase
    end

    logic [31:0] word;

    always_comb begin
        out0  = '0;
        ready = 1'b0;
        word  = '0;
        case (check)
            3'd0: begin
                out0  = out0_r;
                ready = ready_r;
                word  = out1_r;
            end
            3'd1: begin
                out0 = OUT_W'(in_s);
                word = rf_data;
            end
            3'd2: begin
                out0 = OUT_W'(in_s);
                word = m_data;
            end
            3'd3: word = pc;
            3'd4: word = cyc_cnt;
`ifdef PDU_BREAKPOINT_EN
            3'd5: word = bp_r;
`endif
            default: ;
        endcase
    end

    assign an = cnt[REFRESH_W-1 -: AW];

    always_comb begin
        seg = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (an == AW'(i)) seg = word[4*i +: 4];
        end
    end

endmodule
